// File: rtl/mandelbrot_iterator.sv
// Escape-time engine: iterates z <- z^2 + c (signed 4.23) from z = 0 and reports the
// iteration count plus an escaped flag. Latency per iteration: CHECK + 3 x (issue +
// multiplier latency) + UPDATE. Backpressure: operands are held while mul_in_rdy is low,
// and the result is held while out_rdy is low. in_rdy is high only in IDLE.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   c_re, c_im, max_iter        request payload (point c and iteration limit)
//   in_val / in_rdy             request handshake
//   iter_count, escaped         result (completed z updates, 1 = diverged)
//   out_val / out_rdy           result handshake
//   mul_a, mul_b                multiplier operands
//   mul_in_val / mul_in_rdy     multiplier request handshake
//   mul_out                     multiplier product (4.23)
//   mul_out_val / mul_out_rdy   multiplier product handshake
module mandelbrot_iterator #(
  parameter int WIDTH  = 27,
  parameter int FRAC   = 23,
  parameter int ITER_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         c_re,
  input  logic [WIDTH-1:0]         c_im,
  input  logic [ITER_W-1:0]        max_iter,
  input  logic                     in_val,
  output logic                     in_rdy,
  output logic [ITER_W-1:0]        iter_count,
  output logic                     escaped,
  output logic                     out_val,
  input  logic                     out_rdy,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  output logic                     mul_in_val,
  input  logic                     mul_in_rdy,
  input  logic [WIDTH-1:0]         mul_out,
  input  logic                     mul_out_val,
  output logic                     mul_out_rdy
);

  typedef enum logic [3:0] {
    IDLE, CHECK, ISSUE_RR, WAIT_RR, ISSUE_II, WAIT_II, ISSUE_RI, WAIT_RI, UPDATE, DONE
  } state_t;

  // 2.0 and 4.0 in WIDTH+1 bits; saturation bounds of a WIDTH-bit word in WIDTH+2 bits.
  localparam logic signed [WIDTH:0]   TWO_W1  = {{(WIDTH-FRAC-1){1'b0}}, 2'b10, {FRAC{1'b0}}};
  localparam logic signed [WIDTH:0]   FOUR_W1 = {{(WIDTH-FRAC-2){1'b0}}, 3'b100, {FRAC{1'b0}}};
  localparam logic signed [WIDTH+1:0] SAT_MAX = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH+1:0] SAT_MIN = {3'b111, {(WIDTH-1){1'b0}}};

  state_t                    r_state;
  logic signed [WIDTH-1:0]   r_zr, r_zi, r_c_re, r_c_im;
  logic signed [WIDTH-1:0]   r_zr2, r_zi2, r_zrzi;
  logic [ITER_W-1:0]         r_max_iter, r_count;

  logic signed [WIDTH:0]     w_zr_ext, w_zi_ext, w_abs_zr, w_abs_zi, w_sum;
  logic signed [WIDTH+1:0]   w_zr_wide, w_zi_wide;
  logic signed [WIDTH-1:0]   w_zr_next, w_zi_next;
  logic                      w_out_of_box, w_sum_big;
  logic [ITER_W-1:0]         w_count_inc;

  // Magnitude needs one extra bit so that |-8.0| is representable.
  assign w_zr_ext     = {r_zr[WIDTH-1], r_zr};
  assign w_zi_ext     = {r_zi[WIDTH-1], r_zi};
  assign w_abs_zr     = w_zr_ext[WIDTH] ? -w_zr_ext : w_zr_ext;
  assign w_abs_zi     = w_zi_ext[WIDTH] ? -w_zi_ext : w_zi_ext;
  assign w_out_of_box = (w_abs_zr > TWO_W1) || (w_abs_zi > TWO_W1);

  assign w_sum     = {r_zr2[WIDTH-1], r_zr2} + {r_zi2[WIDTH-1], r_zi2};
  assign w_sum_big = (w_sum > FOUR_W1);

  // Two guard bits cover the worst-case growth of a three-term sum before saturation.
  assign w_zr_wide = {{2{r_zr2[WIDTH-1]}}, r_zr2} - {{2{r_zi2[WIDTH-1]}}, r_zi2}
                   + {{2{r_c_re[WIDTH-1]}}, r_c_re};
  assign w_zi_wide = {r_zrzi[WIDTH-1], r_zrzi, 1'b0} + {{2{r_c_im[WIDTH-1]}}, r_c_im};

  always_comb begin
    w_zr_next = w_zr_wide[WIDTH-1:0];
    if (w_zr_wide > SAT_MAX)      w_zr_next = SAT_MAX[WIDTH-1:0];
    else if (w_zr_wide < SAT_MIN) w_zr_next = SAT_MIN[WIDTH-1:0];
  end

  always_comb begin
    w_zi_next = w_zi_wide[WIDTH-1:0];
    if (w_zi_wide > SAT_MAX)      w_zi_next = SAT_MAX[WIDTH-1:0];
    else if (w_zi_wide < SAT_MIN) w_zi_next = SAT_MIN[WIDTH-1:0];
  end

  assign w_count_inc = r_count + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      in_rdy      <= 1'b1;
      out_val     <= 1'b0;
      mul_in_val  <= 1'b0;
      mul_out_rdy <= 1'b0;
      iter_count  <= '0;
      escaped     <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      r_zr        <= '0;
      r_zi        <= '0;
      r_count     <= '0;
      r_c_re      <= '0;
      r_c_im      <= '0;
      r_max_iter  <= '0;
      r_zr2       <= '0;
      r_zi2       <= '0;
      r_zrzi      <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_val) begin
            r_c_re     <= c_re;
            r_c_im     <= c_im;
            r_max_iter <= max_iter;
            r_zr       <= '0;
            r_zi       <= '0;
            r_count    <= '0;
            in_rdy     <= 1'b0;
            if (max_iter == '0) begin
              iter_count <= '0;
              escaped    <= 1'b0;
              out_val    <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (w_out_of_box) begin
            iter_count <= r_count;
            escaped    <= 1'b1;
            out_val    <= 1'b1;
            r_state    <= DONE;
          end else begin
            mul_a      <= r_zr;
            mul_b      <= r_zr;
            mul_in_val <= 1'b1;
            r_state    <= ISSUE_RR;
          end
        end
        ISSUE_RR: begin
          if (mul_in_rdy) begin
            mul_in_val  <= 1'b0;
            mul_out_rdy <= 1'b1;
            r_state     <= WAIT_RR;
          end
        end
        WAIT_RR: begin
          if (mul_out_val) begin
            r_zr2       <= mul_out;
            mul_out_rdy <= 1'b0;
            mul_a       <= r_zi;
            mul_b       <= r_zi;
            mul_in_val  <= 1'b1;
            r_state     <= ISSUE_II;
          end
        end
        ISSUE_II: begin
          if (mul_in_rdy) begin
            mul_in_val  <= 1'b0;
            mul_out_rdy <= 1'b1;
            r_state     <= WAIT_II;
          end
        end
        WAIT_II: begin
          if (mul_out_val) begin
            r_zi2       <= mul_out;
            mul_out_rdy <= 1'b0;
            mul_a       <= r_zr;
            mul_b       <= r_zi;
            mul_in_val  <= 1'b1;
            r_state     <= ISSUE_RI;
          end
        end
        ISSUE_RI: begin
          if (mul_in_rdy) begin
            mul_in_val  <= 1'b0;
            mul_out_rdy <= 1'b1;
            r_state     <= WAIT_RI;
          end
        end
        WAIT_RI: begin
          if (mul_out_val) begin
            r_zrzi      <= mul_out;
            mul_out_rdy <= 1'b0;
            r_state     <= UPDATE;
          end
        end
        UPDATE: begin
          if (w_sum_big) begin
            // Escape detected before this update completes: count stays as is.
            iter_count <= r_count;
            escaped    <= 1'b1;
            out_val    <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_zr    <= w_zr_next;
            r_zi    <= w_zi_next;
            r_count <= w_count_inc;
            if (w_count_inc == r_max_iter) begin
              iter_count <= w_count_inc;
              escaped    <= 1'b0;
              out_val    <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_state <= CHECK;
            end
          end
        end
        DONE: begin
          if (out_rdy) begin
            out_val <= 1'b0;
            in_rdy  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mandelbrot_iterator.md
Name: mandelbrot_iterator

Overview:
- Per-pixel escape-time engine for the Mandelbrot renderer.
- Accepts one complex point c, iterates z <- z^2 + c from z = 0, and returns the iteration count plus an escaped flag.
- Sits directly upstream of karatsuba_multiplier: issues every square/cross product over its val/rdy port and consumes the products. Add/sub/compare logic is local.
- All data is signed 4.23 fixed point. Multiplier product is 4.23.

Parameters:
- WIDTH, 27, fixed-point word width (signed)
- FRAC, 23, fractional bits
- ITER_W, 16, width of max_iter and iter_count

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- c_re  in  WIDTH  real part of c, 4.23
- c_im  in  WIDTH  imaginary part of c, 4.23
- max_iter  in  ITER_W  iteration limit
- in_val  in  1  request valid
- in_rdy  out  1  ready for new request
- iter_count  out  ITER_W  result count
- escaped  out  1  1 = diverged, 0 = hit max_iter
- out_val  out  1  result valid
- out_rdy  in  1  consumer ready
- mul_a  out  WIDTH  multiplier operand a
- mul_b  out  WIDTH  multiplier operand b
- mul_in_val  out  1  multiplier request valid
- mul_in_rdy  in  1  multiplier accepts request
- mul_out  in  WIDTH  multiplier product, 4.23
- mul_out_val  in  1  product valid
- mul_out_rdy  out  1  iterator accepts product

Behaviour:
- One clock (clk). Reset is synchronous and active-high.
- Reset values: in_rdy=1; out_val=0; mul_in_val=0; mul_out_rdy=0; iter_count=0; escaped=0; mul_a=0; mul_b=0. Internal zr, zi and count are cleared. FSM goes to IDLE.
- Reset mid-operation aborts the pixel with no output. The multiplier shares the same reset, so no stale product survives.
- FSM states: IDLE, CHECK, ISSUE_RR, WAIT_RR, ISSUE_II, WAIT_II, ISSUE_RI, WAIT_RI, UPDATE, DONE.
- IDLE:
  - in_rdy=1.
  - On in_val, latch c_re, c_im and max_iter; set zr=zi=0, count=0.
  - If max_iter==0, go to DONE with escaped=0 and count 0, issuing no multiplies. Otherwise go to CHECK.
- CHECK (1 cycle):
  - If |zr|>2.0 or |zi|>2.0 (strict, magnitude computed in WIDTH+1 bits), go to DONE with escaped=1.
  - Otherwise go to ISSUE_RR.
- ISSUE_x:
  - Drive mul_a/mul_b and mul_in_val=1: RR = (zr,zr), II = (zi,zi), RI = (zr,zi).
  - Hold operands stable until mul_in_val && mul_in_rdy, then go to WAIT_x.
- WAIT_x:
  - mul_out_rdy=1.
  - On mul_out_val, capture the product (zr2, zi2 or zrzi) and advance.
  - Products are strictly in order; exactly 3 transactions per iteration.
- UPDATE (1 cycle):
  - Compute sum = zr2+zi2 in WIDTH+1 bits. If sum > 4.0 (strict), go to DONE with escaped=1 and count unchanged.
  - Otherwise:
    - zr <= sat(zr2 - zi2 + c_re)
    - zi <= sat((zrzi<<1) + c_im)
    - Both are computed in WIDTH+2 bits and saturated to [-8.0, 8.0-2^-23].
    - count <= count+1.
  - If count+1 == max_iter, go to DONE with escaped=0. Otherwise go to CHECK.
- DONE:
  - out_val=1, with iter_count and escaped stable until out_rdy.
  - On handshake, return to IDLE. in_rdy goes high the following cycle.
  - in_rdy=0 in every state except IDLE.
- Count semantics: iter_count is the number of completed z updates. When escaped=0, it equals max_iter.
- Latency per non-escaping iteration with a zero-stall multiplier: CHECK + 3 × (issue + multiplier latency) + UPDATE.

Test Plan:
- c=(0,0), max_iter=10 -> iter_count=10, escaped=0, exactly 30 multiplier transactions.
- c_re=0x0800000 (1.0), c_im=0, max_iter=100 -> z: 1, 2, 5; escapes in CHECK with iter_count=3, escaped=1, 9 multiplies.
- c_re=0x7000000 (-2.0), c_im=0, max_iter=50 -> z sticks at 2.0 (sum == 4.0, not > 4.0); iter_count=50, escaped=0.
- max_iter=0, any c -> out_val asserted with iter_count=0, escaped=0, mul_in_val never asserted.
- c=(1.0,0); hold mul_in_rdy low 5 cycles on each request and out_rdy low 4 cycles at DONE -> mul_a/mul_b/mul_in_val stable while stalled; iter_count/escaped held; result still 3/1.
- c=(0,0), max_iter=1000; assert reset in WAIT_II -> next cycle in_rdy=1, out_val=0, mul_in_val=0; a following c=(1.0,0) request returns 3/1.
